cmd_retry_arbiter: RTL and testbench

//  Shares the single command-issue path to the TLX command interface between fresh commands

---
 rtl/cmd_retry_arbiter.sv | 104 ++++++++++
 tb/tb_cmd_retry_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_retry_arbiter.sv
// Arbitrates fresh commands and retries onto one credit-gated, registered TLX command slot.
// Optional macro RETRY_DRAIN_EN: fresh commands also wait while the retry queue is non-empty.
module cmd_retry_arbiter #(
   parameter int TAGW      = 7,
   parameter int CREDITS   = 16,
   parameter int CRW       = 5,
   parameter int RTY_BURST = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            new_valid,
   output logic            new_ready,
   input  logic [TAGW-1:0] new_tag,
   input  logic [1:0]      new_pos,
   output logic            rty_rdy,
   input  logic            rty_valid,
   input  logic [TAGW-1:0] rty_tag,
   input  logic [1:0]      rty_pos,
   input  logic            rty_busy,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic [TAGW-1:0] cmd_tag,
   output logic [1:0]      cmd_pos,
   output logic            cmd_is_retry,
   input  logic            credit_return,
   output logic [CRW-1:0]  credit_cnt,
   output logic            credit_err
);

   localparam int BW = $clog2(RTY_BURST + 1);
   localparam logic [BW-1:0]  BURST_MAX = BW'(RTY_BURST);
   localparam logic [CRW-1:0] CRED_MAX  = CRW'(CREDITS);

   typedef enum logic {EMPTY, FULL} slot_t;

   slot_t         state;
   logic [BW-1:0] burst_cnt;
   logic          can_load;
   logic          starve;
   logic          rty_gnt;
   logic          new_gnt;
   logic          load;

   assign can_load = ((state == EMPTY) || cmd_ready) && (credit_cnt != '0);
   assign starve   = new_valid && (burst_cnt == BURST_MAX);
   assign rty_rdy  = can_load && !starve;
   assign rty_gnt  = rty_valid && rty_rdy;

`ifdef RETRY_DRAIN_EN
   // The burst limit still lets one fresh command through a busy retry queue.
   assign new_ready = can_load && !rty_valid && (!rty_busy || starve);
`else
   logic unused_busy;
   assign unused_busy = rty_busy;
   assign new_ready   = can_load && !rty_valid;
`endif

   assign new_gnt = new_valid && new_ready;
   assign load    = rty_gnt || new_gnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= EMPTY;
         cmd_valid    <= 1'b0;
         cmd_tag      <= '0;
         cmd_pos      <= '0;
         cmd_is_retry <= 1'b0;
         credit_cnt   <= CRED_MAX;
         credit_err   <= 1'b0;
         burst_cnt    <= '0;
      end else begin
         case (state)
            EMPTY: if (load) state <= FULL;
            FULL:  if (cmd_ready && !load) state <= EMPTY;
            default: state <= EMPTY;
         endcase
         cmd_valid <= load || ((state == FULL) && !cmd_ready);

         if (rty_gnt) begin
            cmd_tag      <= rty_tag;
            cmd_pos      <= rty_pos;
            cmd_is_retry <= 1'b1;
         end else if (new_gnt) begin
            cmd_tag      <= new_tag;
            cmd_pos      <= new_pos;
            cmd_is_retry <= 1'b0;
         end

         // A grant and a return in the same cycle cancel out.
         if (load && !credit_return) begin
            credit_cnt <= credit_cnt - 1'b1;
         end else if (!load && credit_return) begin
            if (credit_cnt == CRED_MAX) credit_err <= 1'b1;
            else                        credit_cnt <= credit_cnt + 1'b1;
         end

         if (!new_valid || new_gnt)
            burst_cnt <= '0;
         else if (rty_gnt && (burst_cnt != BURST_MAX))
            burst_cnt <= burst_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cmd_retry_arbiter.sv
// Bench for cmd_retry_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_cmd_retry_arbiter;
   localparam int TAGW = 7;
   localparam int CREDITS = 16;
   localparam int CRW = 5;
   localparam int RTY_BURST = 4;

   logic            clk = 0;
   logic            reset;
   logic            new_valid, new_ready;
   logic [TAGW-1:0] new_tag;
   logic [1:0]      new_pos;
   logic            rty_rdy, rty_valid;
   logic [TAGW-1:0] rty_tag;
   logic [1:0]      rty_pos;
   logic            rty_busy;
   logic            cmd_valid, cmd_ready;
   logic [TAGW-1:0] cmd_tag;
   logic [1:0]      cmd_pos;
   logic            cmd_is_retry;
   logic            credit_return;
   logic [CRW-1:0]  credit_cnt;
   logic            credit_err;

   cmd_retry_arbiter #(.TAGW(TAGW), .CREDITS(CREDITS), .CRW(CRW), .RTY_BURST(RTY_BURST)) dut (
      .clk(clk), .reset(reset),
      .new_valid(new_valid), .new_ready(new_ready), .new_tag(new_tag), .new_pos(new_pos),
      .rty_rdy(rty_rdy), .rty_valid(rty_valid), .rty_tag(rty_tag), .rty_pos(rty_pos),
      .rty_busy(rty_busy),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag), .cmd_pos(cmd_pos),
      .cmd_is_retry(cmd_is_retry),
      .credit_return(credit_return), .credit_cnt(credit_cnt), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TAGW-1:0] tag;
      logic [1:0]      pos;
      logic            retry;
   } cmd_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   // Reference state: slot holds at most one command, credits as a plain count,
   // streak = consecutive retry wins while a fresh command has been waiting.
   cmd_t m_slot[$];
   int   m_cred;
   int   m_streak;
   bit   m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; new_valid = 0; rty_valid = 0; rty_busy = 0; cmd_ready = 0; credit_return = 0;
      new_tag = '0; new_pos = '0; rty_tag = '0; rty_pos = '0;
      @(negedge clk);
      reset = 0;
      m_slot.delete(); m_cred = CREDITS; m_streak = 0; m_err = 0;
      #1;
      check("rst_valid", cmd_valid, 0);
      check("rst_tag", cmd_tag, 0);
      check("rst_pos", cmd_pos, 0);
      check("rst_retry", cmd_is_retry, 0);
      check("rst_cred", credit_cnt, CREDITS);
      check("rst_err", credit_err, 0);
   endtask

   task automatic step(input bit nv, input logic [TAGW-1:0] nt, input logic [1:0] np,
                       input bit rw, input logic [TAGW-1:0] rt, input logic [1:0] rp,
                       input bit busy, input bit crdy, input bit cret);
      bit   can, stv, rr, rv, nr, ng;
      cmd_t c;
      @(negedge clk);
      can = ((m_slot.size() == 0) || crdy) && (m_cred > 0);
      stv = nv && (m_streak >= RTY_BURST);
      rr  = can && !stv;
      rv  = rw && rr;
      nr  = can && !rv;
`ifdef RETRY_DRAIN_EN
      if (busy && !stv) nr = 0;
`endif
      ng  = nv && nr;
      new_valid = nv; new_tag = nt; new_pos = np;
      rty_valid = rv; rty_tag = rt; rty_pos = rp; rty_busy = busy;
      cmd_ready = crdy; credit_return = cret;
      #1;
      check("rty_rdy", rty_rdy, rr);
      check("new_ready", new_ready, nr);
      @(posedge clk);
      if (crdy && m_slot.size() > 0) begin
         c = m_slot.pop_front();
         $display("issue tag=%02h pos=%0d retry=%0d credits=%0d", c.tag, c.pos, c.retry, m_cred);
      end
      if (rv)      m_slot.push_back('{tag: rt, pos: rp, retry: 1'b1});
      else if (ng) m_slot.push_back('{tag: nt, pos: np, retry: 1'b0});
      m_cred = m_cred - ((rv || ng) ? 1 : 0) + (cret ? 1 : 0);
      if (m_cred > CREDITS) begin m_cred = CREDITS; m_err = 1; end
      if (ng || !nv)  m_streak = 0;
      else if (rv)    m_streak = (m_streak + 1 > RTY_BURST) ? RTY_BURST : m_streak + 1;
      #1;
      check("cmd_valid", cmd_valid, (m_slot.size() > 0) ? 1 : 0);
      if (m_slot.size() > 0) begin
         check("cmd_tag", cmd_tag, m_slot[0].tag);
         check("cmd_pos", cmd_pos, m_slot[0].pos);
         check("cmd_is_retry", cmd_is_retry, m_slot[0].retry);
      end
      check("credit_cnt", credit_cnt, m_cred);
      check("credit_err", credit_err, m_err);
   endtask

   initial begin
      int cnt;
      reset = 1;
      new_valid = 0; rty_valid = 0; rty_busy = 0; cmd_ready = 0; credit_return = 0;
      new_tag = '0; new_pos = '0; rty_tag = '0; rty_pos = '0;

      // Credit exhaustion then one returned credit.
      do_reset();
      for (int i = 0; i < 16; i++) step(1, 7'(i), 2'(i), 0, 0, 0, 0, 1, 0);
      check("t1_cred_zero", credit_cnt, 0);
      step(1, 7'h40, 0, 0, 0, 0, 0, 1, 0);
      check("t1_new_ready_low", new_ready, 0);
      step(1, 7'h41, 0, 0, 0, 0, 0, 1, 1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 7'h42, 1, 0, 0, 0, 0, 1, 0);
         if (cmd_valid) cnt++;
      end
      check("t1_one_more", cnt, 1);

      // Retry priority with burst limit.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(1, 7'h10, 1, 1, 7'h60, 2, 1, 1, 1);
         check("t2_pattern", cmd_is_retry, (i % 5 < 4) ? 1 : 0);
      end

      // Back-pressure holds the output slot.
      do_reset();
      step(1, 7'h2A, 3, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 7'h11, 0, 1, 7'h22, 1, 1, 0, 0);
         check("t3_hold_tag", cmd_tag, 7'h2A);
         check("t3_rty_rdy", rty_rdy, 0);
      end

      // Credit return at full count.
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      check("t4_err", credit_err, 1);
      check("t4_cred", credit_cnt, CREDITS);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("t4_err_sticky", credit_err, 1);

      // Grant and return together.
      do_reset();
      for (int i = 0; i < 13; i++) step(1, 7'(i), 0, 0, 0, 0, 0, 1, 0);
      check("t5_cred3", credit_cnt, 3);
      step(1, 7'h55, 0, 0, 0, 0, 0, 1, 1);
      check("t5_cred_same", credit_cnt, 3);

`ifdef RETRY_DRAIN_EN
      do_reset();
      step(1, 7'h33, 2, 0, 0, 0, 1, 1, 0);
      check("t6_stall", new_ready, 0);
      step(1, 7'h33, 2, 0, 0, 0, 0, 1, 0);
      check("t6_issue", cmd_valid, 1);
      check("t6_fresh", cmd_is_retry, 0);
`endif

      // Random traffic.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         bit rw;
         rw = ($urandom_range(0, 2) != 0);
         step(($urandom_range(0, 3) != 0), 7'($urandom), 2'($urandom),
              rw, 7'($urandom), 2'($urandom),
              rw | ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
